booth_rebuild8: RTL and testbench
=================================

// Module: booth_rebuild8
// PURPOSE
//  Sequential radix-2 Booth multiply-accumulate: result = quo * {1'b0,divisor} + rem.
//  Inverse of the non-restoring divider; rebuilds the dividend from a quotient/remainder pair.
//  Sits downstream of the divider for self-check and in the reverse (multiply) datapath.
//  Single-issue: start/busy/done handshake, one Booth step per clock.
// PARAMETERS
//  N      8   quotient/remainder width (signed); divisor width is N-1 (unsigned magnitude)
//  RW     2*N result width (signed)
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     synchronous, active-high
//  start        in   1     request; sampled only in IDLE or DONE
//  quo          in   N     signed multiplier (quotient)
//  divisor      in   N-1   unsigned multiplicand, zero-extended to N bits
//  rem          in   N     signed addend (remainder), sign-extended to RW
//  busy         out  1     high in RUN
//  done         out  1     one-cycle pulse, high in DONE
//  result       out  RW    signed result; held until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
//  FSM states: IDLE, RUN, DONE.
//   IDLE --start--> RUN; DONE --start--> RUN (back-to-back); DONE --!start--> IDLE.
//   RUN --step count==N-1--> DONE; otherwise RUN. start is ignored in RUN.
//  Accept edge: latch M={0,divisor}, Q=quo, Q_-1=0, A=0 (N+1 bits), rem, count=0.
//  Each RUN edge: {Q0,Q_-1}=01 -> A+=M; 10 -> A-=M; 00/11 -> none;
//   then arithmetic right shift of {A,Q,Q_-1}; count++.
//  A is N+1 bits wide, so quo=-2^(N-1) with divisor=2^(N-1)-1 cannot overflow.
//  On the N-th step edge: result <= {A,Q}[RW-1:0] + sext(rem), state=DONE.
//  Latency: done is high in the cycle after the (N+1)th edge counted from the accept edge
//   (accept edge plus N step edges; 9 edges for N=8). Steady-state throughput is one op per N+1 cycles.
//  result changes only on the DONE-entry edge; it is stable while busy.
//  Arithmetic is mod 2^RW; the final add does not saturate.
//  divisor=0: result = sext(rem). quo=0: result = sext(rem).
//  Reset mid-RUN: aborts immediately; no done pulse; result=0.
//  Operand inputs are don't-care except on the accept edge.
// CONFIGURATION
//  `BOOTH_REBUILD_CHECK_EN defined:
//   adds input  dividend_exp  N  (latched on the accept edge)
//   adds output mismatch      1  (reset 0; updated on the DONE-entry edge;
//     = (result != sext(dividend_exp)); held until the next DONE entry).
//  Not defined: both ports are absent; no compare logic.
// STRUCTURE
//  Shared include nrd_defs.vh: N default, state encodings (IDLE/RUN/DONE),
//   and the Booth opcode constants (NOP/ADD/SUB).
//  Sub-module booth_step (combinational): inputs A, Q, Q_-1, M;
//   output is the shifted {A,Q,Q_-1}.
//  Top level holds the FSM, step counter, operand registers, final accumulate and optional compare.
// TESTING
//  1 quo=5, divisor=3, rem=2, start -> done 9 edges later, result=16'h0011, busy high 8 cycles.
//  2 quo=8'hFC(-4), divisor=7, rem=0 -> result=16'hFFE4 (-28).
//  3 quo=8'h80(-128), divisor=127, rem=0 -> result=16'hC080 (-16256); divisor=1 -> 16'hFF80.
//  4 divisor=0, quo=8'h55, rem=8'hFD(-3) -> result=16'hFFFD; start held high in RUN is ignored.
//  5 reset at 4th RUN cycle -> busy=0, done never pulses, result=0;
//    next start with case 1 -> 16'h0011.
//  6 CHECK_EN: case 1 with dividend_exp=17 -> mismatch=0; dividend_exp=18 -> mismatch=1;
//    start asserted in DONE -> RUN on the next edge, no IDLE cycle.

Source files
------------

// File: rtl/booth_rebuild8_pkg.sv
// Shared widths, FSM/opcode encodings and the Booth accumulator payload for booth_rebuild8.
// Optional compare feature in the top is enabled by BOOTH_REBUILD_CHECK_EN.
package booth_rebuild8_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned RW = 2 * N;
  localparam int unsigned AW = N + 1;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Partial-product accumulator {A, Q, Q_-1}
  typedef struct packed {
    logic [AW-1:0] a;
    logic [N-1:0]  q;
    logic          q_m1;
  } booth_acc_t;

  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    booth_op_e op;
    case ({q0, q_m1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_rebuild8_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then arithmetic
// right shift of {A, Q, Q_-1}. Purely combinational.
module booth_step
  import booth_rebuild8_pkg::*;
(
  input  logic [AW-1:0] i_a,
  input  logic [N-1:0]  i_q,
  input  logic          i_q_m1,
  input  logic [N-2:0]  i_m,
  output booth_acc_t    o_acc_c
);

  logic [AW-1:0] w_m_ext;
  logic [AW-1:0] w_sum;
  booth_op_e     w_op;

  assign w_m_ext = {2'b00, i_m};
  assign w_op    = booth_decode(i_q[0], i_q_m1);

  always_comb begin
    w_sum = i_a;
    case (w_op)
      OP_ADD:  w_sum = i_a + w_m_ext;
      OP_SUB:  w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
  end

  // Sign bit of A is replicated; the old Q_-1 falls off the bottom
  always_comb begin
    o_acc_c.a    = {w_sum[AW-1], w_sum[AW-1:1]};
    o_acc_c.q    = {w_sum[0], i_q[N-1:1]};
    o_acc_c.q_m1 = i_q[0];
  end

endmodule

// File: rtl/booth_rebuild8.sv
// Sequential Booth multiply-accumulate: result = quo * {0,divisor} + sext(rem).
// Define BOOTH_REBUILD_CHECK_EN to add the dividend_exp input and mismatch output.
module booth_rebuild8
  import booth_rebuild8_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  quo,
  input  logic [N-2:0]  divisor,
  input  logic [N-1:0]  rem,
`ifdef BOOTH_REBUILD_CHECK_EN
  input  logic [N-1:0]  dividend_exp,
  output logic          mismatch,
`endif
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_busy;
  logic          r_done;
  logic          w_busy_nxt;
  logic          w_done_nxt;

  logic [N-2:0]  r_m;
  logic [AW-1:0] r_a;
  logic [N-1:0]  r_q;
  logic          r_q_m1;
  logic [N-1:0]  r_rem;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_result;

  logic          w_accept;
  logic          w_last;
  booth_acc_t    w_step;
  logic [RW-1:0] w_final;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(N - 1));

  booth_step u_step (
    .i_a     (r_a),
    .i_q     (r_q),
    .i_q_m1  (r_q_m1),
    .i_m     (r_m),
    .o_acc_c (w_step)
  );

  // Low RW bits of the shifted {A,Q} plus the sign-extended remainder, mod 2^RW
  assign w_final = {w_step.a[N-1:0], w_step.q} + {{(RW - N){r_rem[N-1]}}, r_rem};

  // State register with registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_RUN:  w_busy_nxt = 1'b1;
      ST_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, Booth iteration and final accumulate
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m      <= '0;
      r_a      <= '0;
      r_q      <= '0;
      r_q_m1   <= 1'b0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_m    <= divisor;
      r_a    <= '0;
      r_q    <= quo;
      r_q_m1 <= 1'b0;
      r_rem  <= rem;
      r_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      r_a    <= w_step.a;
      r_q    <= w_step.q;
      r_q_m1 <= w_step.q_m1;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

`ifdef BOOTH_REBUILD_CHECK_EN
  logic [N-1:0] r_dexp;
  logic         r_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dexp     <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) r_dexp <= dividend_exp;
      if (w_last)   r_mismatch <= (w_final != {{(RW - N){r_dexp[N-1]}}, r_dexp});
    end
  end

  assign mismatch = r_mismatch;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_booth_rebuild8.sv
// Scoreboard bench for booth_rebuild8: expectations are queued at launch and
// checked when done pulses. Define BOOTH_REBUILD_CHECK_EN to also check mismatch.
module tb_booth_rebuild8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  quo;
  logic [6:0]  divisor;
  logic [7:0]  rem;
  logic        busy;
  logic        done;
  logic [15:0] result;
`ifdef BOOTH_REBUILD_CHECK_EN
  logic [7:0]  dividend_exp;
  logic        mismatch;
`endif

  typedef struct packed {
    logic [15:0] res;
    logic        mm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  booth_rebuild8 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .quo          (quo),
    .divisor      (divisor),
    .rem          (rem),
`ifdef BOOTH_REBUILD_CHECK_EN
    .dividend_exp (dividend_exp),
    .mismatch     (mismatch),
`endif
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one request and queue its expected result
  task automatic launch(input logic [7:0] q, input logic [6:0] d, input logic [7:0] r,
                        input logic [7:0] dx);
    exp_t e;
    int   v;
    v     = $signed(q) * $signed({1'b0, d}) + $signed(r);
    e.res = 16'(v);
    e.mm  = (e.res != {{8{dx[7]}}, dx});
    quo     = q;
    divisor = d;
    rem     = r;
`ifdef BOOTH_REBUILD_CHECK_EN
    dividend_exp = dx;
`endif
    start = 1'b1;
    sb.push_back(e);
  endtask

  task automatic scramble();
    quo     = 8'($urandom);
    divisor = 7'($urandom);
    rem     = 8'($urandom);
`ifdef BOOTH_REBUILD_CHECK_EN
    dividend_exp = 8'($urandom);
`endif
  endtask

  // Called on the negedge after an accept edge; returns with done high (or budget gone)
  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [7:0] q, input logic [6:0] d, input logic [7:0] r,
                        input logic [7:0] dx, input bit hold);
    int nb;
    @(negedge clk);
    launch(q, d, r, dx);
    @(negedge clk);
    if (!hold) start = 1'b0;
    scramble();
    wait_done(nb);
    chk("busy_cycles", nb, 8);
    chk("done_seen", {31'd0, done}, 1);
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 0);
      end else begin
        e = sb.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.res});
`ifdef BOOTH_REBUILD_CHECK_EN
        chk("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
`endif
      end
    end
  end

  initial begin
    int nb;
    int dc;
    reset   = 1'b1;
    start   = 1'b0;
    quo     = '0;
    divisor = '0;
    rem     = '0;
`ifdef BOOTH_REBUILD_CHECK_EN
    dividend_exp = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", {16'd0, result}, 0);
`ifdef BOOTH_REBUILD_CHECK_EN
    chk("rst_mismatch", {31'd0, mismatch}, 0);
`endif

    run_op(8'd5,   7'd3,   8'd2,   8'd17,  1'b0);
    run_op(8'hFC,  7'd7,   8'd0,   8'hE4,  1'b0);
    run_op(8'h80,  7'd127, 8'd0,   8'h80,  1'b0);
    run_op(8'h80,  7'd1,   8'd0,   8'h80,  1'b0);
    run_op(8'h55,  7'd0,   8'hFD,  8'hFD,  1'b1);
    run_op(8'd0,   7'd99,  8'h7F,  8'h7F,  1'b0);
    run_op(8'd5,   7'd3,   8'd2,   8'd18,  1'b0);

    // Back-to-back: start in DONE goes straight to RUN
    @(negedge clk);
    launch(8'd5, 7'd3, 8'd2, 8'd17);
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    chk("b2b_first_busy", nb, 8);
    launch(8'hFC, 7'd7, 8'd0, 8'hE4);
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 1);
    chk("b2b_done", {31'd0, done}, 0);
    start = 1'b0;
    wait_done(nb);
    chk("b2b_second_busy", nb, 8);
    @(negedge clk);

    // Reset in the 4th RUN cycle aborts without a done pulse
    launch(8'd5, 7'd3, 8'd2, 8'd17);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_result", {16'd0, result}, 0);
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort_no_done", dc, 0);
    run_op(8'd5, 7'd3, 8'd2, 8'd17, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] q;
      logic [6:0] d;
      logic [7:0] r;
      logic [7:0] dx;
      q  = 8'($urandom);
      d  = 7'($urandom);
      r  = 8'($urandom);
      dx = 8'($urandom);
      run_op(q, d, r, dx, 1'b0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
